// File: rtl/exc_ctrl_pkg.sv
// Shared types for the commit-stage exception controller: cp0 write bundle,
// ExcCode constants, FSM states and the bad-address source select.
`ifndef W_ADDR
`define W_ADDR 32
`endif
`ifndef W_INTV
`define W_INTV 8
`endif

package exc_ctrl_pkg;

  typedef struct packed {
    logic                 we;
    logic                 exl;
    logic                 bd;
    logic [4:0]           exc;
    logic [`W_ADDR-1:0]   epc;
    logic [`W_ADDR-1:0]   bva;
  } reg_error;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  typedef enum logic [1:0] {IDLE, DRAIN, REDIRECT} exc_state_t;

  typedef enum logic [1:0] {BVA_KEEP, BVA_PC, BVA_MADDR} bva_sel_t;

endpackage

// File: rtl/exc_ctrl_prio.sv
// Combinational priority encoder: picks the winning exception (or ERET) on the
// committing instruction and decides whether the controller takes it this cycle.
module exc_prio
  import exc_ctrl_pkg::*;
(
  input  logic       idle,
  input  logic       cm_valid,
  input  logic       cm_stall,
  input  logic       intr,
  input  logic       adel_if,
  input  logic       ri,
  input  logic       ov,
  input  logic       sys,
  input  logic       bp,
  input  logic       adel_d,
  input  logic       ades_d,
  input  logic       eret,
  output logic       take,
  output logic       is_eret,
  output logic [4:0] exc,
  output bva_sel_t   bva_sel
);

  logic hit;
  logic eret_sel;

  always_comb begin
    exc      = EXC_INT;
    bva_sel  = BVA_KEEP;
    eret_sel = 1'b0;
    hit      = 1'b1;
    if (intr) begin
      exc = EXC_INT;
    end else if (adel_if) begin
      exc     = EXC_ADEL;
      bva_sel = BVA_PC;
    end else if (ri) begin
      exc = EXC_RI;
    end else if (ov) begin
      exc = EXC_OV;
    end else if (sys) begin
      exc = EXC_SYS;
    end else if (bp) begin
      exc = EXC_BP;
    end else if (adel_d) begin
      exc     = EXC_ADEL;
      bva_sel = BVA_MADDR;
    end else if (ades_d) begin
      exc     = EXC_ADES;
      bva_sel = BVA_MADDR;
    end else if (eret) begin
      eret_sel = 1'b1;
    end else begin
      hit = 1'b0;
    end
  end

  assign take    = idle && cm_valid && !cm_stall && hit;
  assign is_eret = take && eret_sel;

endmodule

// File: rtl/exc_ctrl.sv
// Precise-exception controller at commit: flush at take (T), cp0 write at T+1,
// redirect once the data bus drains (earliest T+2, forced after MAX_DRAIN cycles).
`ifndef W_ADDR
`define W_ADDR 32
`endif
`ifndef W_INTV
`define W_INTV 8
`endif

module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [`W_ADDR-1:0] EXC_VECTOR = 32'hBFC00380,
  parameter int                 MAX_DRAIN  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cm_valid,
  input  logic               cm_stall,
  input  logic [`W_ADDR-1:0] cm_pc,
  input  logic               cm_bd,
  input  logic               cm_adel_if,
  input  logic               cm_ri,
  input  logic               cm_ov,
  input  logic               cm_sys,
  input  logic               cm_bp,
  input  logic               cm_adel_d,
  input  logic               cm_ades_d,
  input  logic [`W_ADDR-1:0] cm_maddr,
  input  logic               cm_eret,
  input  logic               mem_busy,
  input  logic [`W_INTV-1:0] intr_vect,
  input  logic [`W_ADDR-1:0] er_epc,
  output reg_error           cp0w,
  output logic               flush,
  output logic               redirect,
  output logic [`W_ADDR-1:0] redirect_pc,
  output logic               drain_timeout
);

  localparam int CNT_W = (MAX_DRAIN > 1) ? $clog2(MAX_DRAIN) : 1;

  exc_state_t         state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               take, is_eret, timeout_set;
  logic [4:0]         exc_code;
  bva_sel_t           bva_sel;
  reg_error           cp0w_nxt;
  logic               sh_bd;
  logic [4:0]         sh_exc;
  logic [`W_ADDR-1:0] sh_bva;
  logic               eret_q;
  logic [`W_ADDR-1:0] eret_pc_q;

  exc_prio u_prio (
    .idle     (state == IDLE),
    .cm_valid (cm_valid),
    .cm_stall (cm_stall),
    .intr     (|intr_vect),
    .adel_if  (cm_adel_if),
    .ri       (cm_ri),
    .ov       (cm_ov),
    .sys      (cm_sys),
    .bp       (cm_bp),
    .adel_d   (cm_adel_d),
    .ades_d   (cm_ades_d),
    .eret     (cm_eret),
    .take     (take),
    .is_eret  (is_eret),
    .exc      (exc_code),
    .bva_sel  (bva_sel)
  );

  // ERET rewrites only EXL/EPC; the read-only fields are replayed from the shadow.
  always_comb begin
    cp0w_nxt = '0;
    if (take) begin
      cp0w_nxt.we = 1'b1;
      if (is_eret) begin
        cp0w_nxt.exl = 1'b0;
        cp0w_nxt.epc = er_epc;
        cp0w_nxt.bd  = sh_bd;
        cp0w_nxt.exc = sh_exc;
        cp0w_nxt.bva = sh_bva;
      end else begin
        cp0w_nxt.exl = 1'b1;
        cp0w_nxt.bd  = cm_bd;
        cp0w_nxt.exc = exc_code;
        cp0w_nxt.epc = cm_bd ? (cm_pc - `W_ADDR'(4)) : cm_pc;
        case (bva_sel)
          BVA_PC:    cp0w_nxt.bva = cm_pc;
          BVA_MADDR: cp0w_nxt.bva = cm_maddr;
          default:   cp0w_nxt.bva = sh_bva;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cp0w          <= '0;
      sh_bd         <= 1'b0;
      sh_exc        <= '0;
      sh_bva        <= '0;
      eret_q        <= 1'b0;
      eret_pc_q     <= '0;
      state         <= IDLE;
      cnt           <= '0;
      drain_timeout <= 1'b0;
    end else begin
      cp0w          <= cp0w_nxt;
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      drain_timeout <= drain_timeout | timeout_set;
      if (take) begin
        sh_bd     <= cp0w_nxt.bd;
        sh_exc    <= cp0w_nxt.exc;
        sh_bva    <= cp0w_nxt.bva;
        eret_q    <= is_eret;
        eret_pc_q <= er_epc;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    flush       = take;
    redirect    = 1'b0;
    redirect_pc = '0;
    timeout_set = 1'b0;
    case (state)
      IDLE: begin
        if (take) begin
          state_nxt = DRAIN;
          cnt_nxt   = '0;
        end
      end
      DRAIN: begin
        flush   = 1'b1;
        cnt_nxt = cnt + CNT_W'(1);
        if (!mem_busy) begin
          state_nxt = REDIRECT;
        end else if (cnt == CNT_W'(MAX_DRAIN - 1)) begin
          state_nxt   = REDIRECT;
          timeout_set = 1'b1;
        end
      end
      REDIRECT: begin
        flush       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = eret_q ? eret_pc_q : EXC_VECTOR;
        state_nxt   = IDLE;
        cnt_nxt     = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios plus randomized commits
// compared against a priority-table / drain-arithmetic reference model.
`ifndef W_ADDR
`define W_ADDR 32
`endif
`ifndef W_INTV
`define W_INTV 8
`endif

module tb_exc_ctrl;
  import exc_ctrl_pkg::*;

  localparam logic [31:0] VEC = 32'hBFC00380;

  logic clk = 1'b0;
  logic rst_n;
  logic cm_valid, cm_stall, cm_bd, cm_adel_if, cm_ri, cm_ov, cm_sys, cm_bp;
  logic cm_adel_d, cm_ades_d, cm_eret, mem_busy;
  logic [31:0] cm_pc, cm_maddr, er_epc;
  logic [`W_INTV-1:0] intr_vect;
  reg_error cp0w;
  logic flush, redirect, drain_timeout;
  logic [31:0] redirect_pc;

  int total = 0;
  int bad = 0;

  // reference-model state
  logic        m_bd = 1'b0;
  logic [4:0]  m_exc = '0;
  logic [31:0] m_bva = '0;
  logic        m_to = 1'b0;

  exc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cm_valid(cm_valid), .cm_stall(cm_stall),
    .cm_pc(cm_pc), .cm_bd(cm_bd), .cm_adel_if(cm_adel_if), .cm_ri(cm_ri),
    .cm_ov(cm_ov), .cm_sys(cm_sys), .cm_bp(cm_bp), .cm_adel_d(cm_adel_d),
    .cm_ades_d(cm_ades_d), .cm_maddr(cm_maddr), .cm_eret(cm_eret),
    .mem_busy(mem_busy), .intr_vect(intr_vect), .er_epc(er_epc),
    .cp0w(cp0w), .flush(flush), .redirect(redirect),
    .redirect_pc(redirect_pc), .drain_timeout(drain_timeout)
  );

  always #5 clk = ~clk;

  task automatic clear_commit();
    cm_valid = 0; cm_stall = 0; cm_bd = 0; cm_adel_if = 0; cm_ri = 0;
    cm_ov = 0; cm_sys = 0; cm_bp = 0; cm_adel_d = 0; cm_ades_d = 0;
    cm_eret = 0; intr_vect = '0;
  endtask

  // Expected write bundle from the priority table applied to the current inputs.
  function automatic reg_error exp_cp0w();
    reg_error r;
    logic fl [8];
    int codes [8];
    int win;
    codes = '{0, 4, 10, 12, 8, 9, 4, 5};
    fl = '{intr_vect != 0, cm_adel_if, cm_ri, cm_ov, cm_sys, cm_bp, cm_adel_d, cm_ades_d};
    win = -1;
    for (int i = 7; i >= 0; i--) if (fl[i]) win = i;
    r = '0;
    r.we = 1'b1;
    if (win >= 0) begin
      r.exl = 1'b1;
      r.bd  = cm_bd;
      r.exc = 5'(codes[win]);
      r.epc = cm_bd ? cm_pc - 32'd4 : cm_pc;
      r.bva = (win == 1) ? cm_pc : (win >= 6) ? cm_maddr : m_bva;
    end else begin
      r.exl = 1'b0;
      r.epc = er_epc;
      r.bd  = m_bd;
      r.exc = m_exc;
      r.bva = m_bva;
    end
    return r;
  endfunction

  function automatic int exp_lat(input int busy_n);
    return 2 + ((busy_n < 15) ? busy_n : 15);
  endfunction

  task automatic model_commit(input reg_error e, input int busy_n);
    m_bd = e.bd; m_exc = e.exc; m_bva = e.bva;
    if (busy_n > 15) m_to = 1'b1;
  endtask

  // Drives one taken commit (inputs preset by caller, cm_valid raised here) and
  // mem_busy high for the first busy_n DRAIN cycles; returns observations.
  task automatic fire(input int busy_n, output logic f_t, output reg_error w1,
                      output logic we2, output int lat, output logic [31:0] rpc,
                      output logic gap, output logic after);
    @(negedge clk); cm_valid = 1; #1; f_t = flush;
    @(negedge clk); clear_commit(); mem_busy = (busy_n > 0); #1; w1 = cp0w;
    lat = -1; rpc = '0; gap = 0; we2 = 1;
    for (int c = 2; c < 60; c++) begin
      @(negedge clk); mem_busy = ((c - 1) < busy_n); #1;
      if (c == 2) we2 = cp0w.we;
      if (!flush) gap = 1;
      if (redirect) begin lat = c; rpc = redirect_pc; break; end
    end
    @(negedge clk); mem_busy = 0; #1; after = redirect | flush | cp0w.we;
  endtask

  task automatic test_reset();
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b want=0", flush); end
    total++; if (redirect !== 1'b0) begin bad++; $display("FAIL reset_redirect got=%b want=0", redirect); end
    total++; if (redirect_pc !== 32'h0) begin bad++; $display("FAIL reset_rpc got=%h want=0", redirect_pc); end
    total++; if (drain_timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", drain_timeout); end
    total++; if (cp0w !== '0) begin bad++; $display("FAIL reset_cp0w got=%h want=0", cp0w); end
  endtask

  task automatic test_overflow();
    reg_error e, w1; logic f_t, we2, gap, after; int lat; logic [31:0] rpc;
    clear_commit(); cm_pc = 32'h80001000; cm_ov = 1;
    e = exp_cp0w();
    fire(0, f_t, w1, we2, lat, rpc, gap, after);
    model_commit(e, 0);
    total++; if (f_t !== 1'b1) begin bad++; $display("FAIL ov_flush_T got=%b want=1", f_t); end
    total++; if (w1 !== e) begin bad++; $display("FAIL ov_cp0w got=%h want=%h", w1, e); end
    total++; if (w1.exc !== 5'd12 || w1.epc !== 32'h80001000 || w1.exl !== 1'b1)
      begin bad++; $display("FAIL ov_fields got exc=%0d epc=%h exl=%b want 12/80001000/1", w1.exc, w1.epc, w1.exl); end
    total++; if (we2 !== 1'b0) begin bad++; $display("FAIL ov_we_pulse got=%b want=0", we2); end
    total++; if (lat !== 2) begin bad++; $display("FAIL ov_latency got=%0d want=2", lat); end
    total++; if (rpc !== VEC) begin bad++; $display("FAIL ov_rpc got=%h want=%h", rpc, VEC); end
    total++; if (gap !== 1'b0 || after !== 1'b0) begin bad++; $display("FAIL ov_flush_hold got gap=%b after=%b want 0/0", gap, after); end
  endtask

  task automatic test_ades_bd();
    reg_error e, w1; logic f_t, we2, gap, after; int lat; logic [31:0] rpc;
    clear_commit(); cm_pc = 32'h80002004; cm_bd = 1; cm_maddr = 32'h3; cm_ades_d = 1;
    e = exp_cp0w();
    fire(0, f_t, w1, we2, lat, rpc, gap, after);
    model_commit(e, 0);
    total++; if (w1 !== e) begin bad++; $display("FAIL ades_cp0w got=%h want=%h", w1, e); end
    total++; if (w1.exc !== 5'd5 || w1.bd !== 1'b1 || w1.epc !== 32'h80002000 || w1.bva !== 32'h3)
      begin bad++; $display("FAIL ades_fields got exc=%0d bd=%b epc=%h bva=%h", w1.exc, w1.bd, w1.epc, w1.bva); end
  endtask

  task automatic test_int_wins();
    reg_error e, w1; logic f_t, we2, gap, after; int lat; logic [31:0] rpc;
    clear_commit(); cm_pc = 32'h80004000; intr_vect = 8'h04; cm_ri = 1;
    e = exp_cp0w();
    fire(0, f_t, w1, we2, lat, rpc, gap, after);
    model_commit(e, 0);
    total++; if (w1.exc !== 5'd0 || w1.epc !== 32'h80004000 || w1 !== e)
      begin bad++; $display("FAIL int_ri got=%h want=%h", w1, e); end
    clear_commit(); cm_pc = 32'h80004100; intr_vect = 8'h01; cm_eret = 1; er_epc = 32'h80009000;
    e = exp_cp0w();
    fire(0, f_t, w1, we2, lat, rpc, gap, after);
    model_commit(e, 0);
    total++; if (w1.exc !== 5'd0 || w1.exl !== 1'b1 || w1.epc !== 32'h80004100)
      begin bad++; $display("FAIL int_eret got exc=%0d exl=%b epc=%h want 0/1/80004100", w1.exc, w1.exl, w1.epc); end
    total++; if (rpc !== VEC) begin bad++; $display("FAIL int_eret_rpc got=%h want=%h", rpc, VEC); end
  endtask

  task automatic test_eret();
    reg_error e, w1; logic f_t, we2, gap, after; int lat; logic [31:0] rpc;
    // prime the shadow with an address error so bva is known
    clear_commit(); cm_pc = 32'h80005000; cm_maddr = 32'h1234_5677; cm_adel_d = 1;
    e = exp_cp0w();
    fire(0, f_t, w1, we2, lat, rpc, gap, after);
    model_commit(e, 0);
    clear_commit(); cm_pc = 32'h80005008; cm_eret = 1; er_epc = 32'h80003000;
    e = exp_cp0w();
    fire(0, f_t, w1, we2, lat, rpc, gap, after);
    model_commit(e, 0);
    total++; if (w1 !== e) begin bad++; $display("FAIL eret_cp0w got=%h want=%h", w1, e); end
    total++; if (w1.exl !== 1'b0 || w1.epc !== 32'h80003000 || w1.bva !== 32'h1234_5677)
      begin bad++; $display("FAIL eret_fields got exl=%b epc=%h bva=%h", w1.exl, w1.epc, w1.bva); end
    total++; if (rpc !== 32'h80003000) begin bad++; $display("FAIL eret_rpc got=%h want=80003000", rpc); end
  endtask

  task automatic test_drain();
    reg_error e, w1; logic f_t, we2, gap, after; int lat; logic [31:0] rpc;
    clear_commit(); cm_pc = 32'h80006000; cm_sys = 1;
    e = exp_cp0w();
    fire(3, f_t, w1, we2, lat, rpc, gap, after);
    model_commit(e, 3);
    total++; if (lat !== 5) begin bad++; $display("FAIL drain3_latency got=%0d want=5", lat); end
    total++; if (drain_timeout !== 1'b0) begin bad++; $display("FAIL drain3_timeout got=%b want=0", drain_timeout); end
    total++; if (gap !== 1'b0) begin bad++; $display("FAIL drain3_flush_gap got=%b want=0", gap); end
    clear_commit(); cm_pc = 32'h80006010; cm_bp = 1;
    e = exp_cp0w();
    fire(40, f_t, w1, we2, lat, rpc, gap, after);
    model_commit(e, 40);
    total++; if (lat !== 17) begin bad++; $display("FAIL drain40_latency got=%0d want=17", lat); end
    total++; if (drain_timeout !== 1'b1) begin bad++; $display("FAIL drain40_timeout got=%b want=1", drain_timeout); end
  endtask

  task automatic test_ignore();
    clear_commit(); cm_pc = 32'h80007000; cm_ov = 1;
    @(negedge clk); #1;
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL novalid_flush got=%b want=0", flush); end
    cm_valid = 1; cm_stall = 1;
    @(negedge clk); #1;
    total++; if (flush !== 1'b0 || cp0w.we !== 1'b0) begin bad++; $display("FAIL stall_take got flush=%b we=%b want 0/0", flush, cp0w.we); end
    cm_ov = 0; cm_stall = 0;
    @(negedge clk); #1;
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL noexc_flush got=%b want=0", flush); end
    @(negedge clk); #1;
    total++; if (cp0w.we !== 1'b0) begin bad++; $display("FAIL noexc_we got=%b want=0", cp0w.we); end
    clear_commit();
  endtask

  task automatic test_reset_mid_drain();
    reg_error e, w1; logic f_t, we2, gap, after; int lat; logic [31:0] rpc;
    clear_commit(); cm_pc = 32'h80008000; cm_ov = 1;
    @(negedge clk); cm_valid = 1;
    @(negedge clk); clear_commit(); mem_busy = 1;
    @(negedge clk); #1;
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL middrain_flush got=%b want=1", flush); end
    #2 rst_n = 0; #1;
    total++; if (flush !== 1'b0 || redirect !== 1'b0 || cp0w.we !== 1'b0)
      begin bad++; $display("FAIL rst_drop got flush=%b redir=%b we=%b want 0/0/0", flush, redirect, cp0w.we); end
    total++; if (drain_timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%b want=0", drain_timeout); end
    m_bd = 0; m_exc = '0; m_bva = '0; m_to = 0;
    @(negedge clk); rst_n = 1; mem_busy = 0;
    clear_commit(); cm_pc = 32'h80008100; cm_ri = 1;
    e = exp_cp0w();
    fire(0, f_t, w1, we2, lat, rpc, gap, after);
    model_commit(e, 0);
    total++; if (w1 !== e || lat !== 2) begin bad++; $display("FAIL post_rst got cp0w=%h lat=%0d want %h/2", w1, lat, e); end
  endtask

  task automatic test_random();
    reg_error e, w1; logic f_t, we2, gap, after; int lat; logic [31:0] rpc, epc_exp; int bn;
    for (int it = 0; it < 30; it++) begin
      clear_commit();
      cm_pc = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
      cm_maddr = $urandom; er_epc = $urandom;
      cm_bd = 1'($urandom_range(0, 1));
      cm_adel_if = ($urandom_range(0, 7) == 0); cm_ri = ($urandom_range(0, 7) == 0);
      cm_ov = ($urandom_range(0, 7) == 0); cm_sys = ($urandom_range(0, 7) == 0);
      cm_bp = ($urandom_range(0, 7) == 0); cm_adel_d = ($urandom_range(0, 5) == 0);
      cm_ades_d = ($urandom_range(0, 5) == 0); cm_eret = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 5) == 0) intr_vect = `W_INTV'($urandom);
      if (!(cm_adel_if | cm_ri | cm_ov | cm_sys | cm_bp | cm_adel_d | cm_ades_d | cm_eret | (intr_vect != 0)))
        cm_eret = 1;
      bn = $urandom_range(0, 20);
      e = exp_cp0w();
      epc_exp = e.exl ? VEC : er_epc;
      fire(bn, f_t, w1, we2, lat, rpc, gap, after);
      model_commit(e, bn);
      total++; if (w1 !== e) begin bad++; $display("FAIL rnd%0d_cp0w got=%h want=%h", it, w1, e); end
      total++; if (lat !== exp_lat(bn) || rpc !== epc_exp)
        begin bad++; $display("FAIL rnd%0d_redirect got lat=%0d pc=%h want %0d/%h", it, lat, rpc, exp_lat(bn), epc_exp); end
      total++; if (drain_timeout !== m_to || f_t !== 1'b1 || we2 !== 1'b0 || gap !== 1'b0 || after !== 1'b0)
        begin bad++; $display("FAIL rnd%0d_ctl got to=%b f=%b we2=%b gap=%b after=%b want to=%b 1/0/0/0", it, drain_timeout, f_t, we2, gap, after, m_to); end
    end
  endtask

  initial begin
    rst_n = 0; mem_busy = 0; cm_pc = '0; cm_maddr = '0; er_epc = '0;
    clear_commit();
    repeat (3) @(negedge clk);
    #1 test_reset();
    @(negedge clk); rst_n = 1;
    @(negedge clk); #1 test_reset();
    test_overflow();
    test_ades_bd();
    test_int_wins();
    test_eret();
    test_drain();
    test_ignore();
    test_reset_mid_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
